// File: rtl/nwr_arb_pkg.sv
// Shared definitions for the NWRITE stream arbiter.
//   arb_state_t : arbiter FSM states
//   DATA_W, ADDR_W, SIZE_W : default stream, address and size widths
//   MAX_SRC     : largest supported source count
//   rr_pick     : round-robin pick returning a one-hot grant
package nwr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER      = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 34;
  localparam int SIZE_W  = 20;
  localparam int MAX_SRC = 8;

  // Scans ptr+1 .. ptr+n (mod n) and returns the first requester one-hot.
  // Only the low n bits of req are considered; n must be 1..MAX_SRC.
  function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                  input logic [2:0]         ptr,
                                                  input int                 n);
    logic [MAX_SRC-1:0] gnt;
    logic               found;
    logic               hit;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      idx      = (int'(ptr) + k) % n;
      hit      = !found && (k <= n) && req[idx];
      gnt[idx] = gnt[idx] | hit;
      found    = found | hit;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req   : per-source request vector
//   ptr   : index of the most recently served source
//   grant : one-hot winner (0 when no request)
module rr_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant
);
  import nwr_arb_pkg::*;

  // Widen to the package function's fixed width and narrow the result back.
  always_comb begin
    grant = NUM_SRC'(rr_pick(MAX_SRC'(req), 3'(ptr), NUM_SRC));
  end

endmodule

// File: rtl/nwr_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the NWRITE user stream port
// between NUM_SRC packet sources (log_clk domain).
//   log_clk/log_rst      : clock, asynchronous active-high reset
//   src_*                : packed per-source streams (source i in slice i)
//   user_*               : muxed stream toward the NWRITE engine; tsize/addr
//                          are latched at grant and held until the next grant
//   nwr_busy_in          : blocks new grants (never an active packet)
//   nwr_done_in          : completion pulse that releases the grant
//   grant_o / arb_busy_o : current one-hot grant, busy in XFER or WAIT_DONE
// Build option NWR_ARB_STATS_EN adds pkt_cnt_o, a saturating per-source count
// of completed packets (CNT_W bits each).
module nwr_stream_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = nwr_arb_pkg::DATA_W,
  parameter int ADDR_W  = nwr_arb_pkg::ADDR_W,
  parameter int SIZE_W  = nwr_arb_pkg::SIZE_W
`ifdef NWR_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                         log_clk,
  input  logic                         log_rst,
  input  logic [NUM_SRC-1:0]           src_tvalid_in,
  output logic [NUM_SRC-1:0]           src_tready_o,
  input  logic [NUM_SRC*DATA_W-1:0]    src_tdata_in,
  input  logic [NUM_SRC*DATA_W/8-1:0]  src_tkeep_in,
  input  logic [NUM_SRC-1:0]           src_tfirst_in,
  input  logic [NUM_SRC-1:0]           src_tlast_in,
  input  logic [NUM_SRC*SIZE_W-1:0]    src_tsize_in,
  input  logic [NUM_SRC*ADDR_W-1:0]    src_addr_in,
  input  logic                         user_tready_in,
  output logic                         user_tvalid_o,
  output logic                         user_tfirst_o,
  output logic                         user_tlast_o,
  output logic [DATA_W-1:0]            user_tdata_o,
  output logic [DATA_W/8-1:0]          user_tkeep_o,
  output logic [SIZE_W-1:0]            user_tsize_o,
  output logic [ADDR_W-1:0]            user_addr_o,
  input  logic                         nwr_busy_in,
  input  logic                         nwr_done_in,
  output logic [NUM_SRC-1:0]           grant_o,
  output logic                         arb_busy_o
`ifdef NWR_ARB_STATS_EN
  , output logic [NUM_SRC*CNT_W-1:0]   pkt_cnt_o
`endif
);
  import nwr_arb_pkg::*;

  localparam int KEEP_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(NUM_SRC);

  arb_state_t          state_r, state_nxt_s;
  logic [NUM_SRC-1:0]  req_s, pick_s, grant_r, src_tready_s;
  logic [PTR_W-1:0]    rr_ptr_r, g_idx_s, pick_idx_s;
  logic [SIZE_W-1:0]   tsize_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                done_seen_r, arb_busy_r, take_s, hs_last_s;
  logic                user_tvalid_s, user_tfirst_s, user_tlast_s;
  logic [DATA_W-1:0]   user_tdata_s;
  logic [KEEP_W-1:0]   user_tkeep_s;

  // Only a packet head may request; a stray mid-packet beat never wins.
  always_comb begin
    req_s = src_tvalid_in & src_tfirst_in;
  end

  rr_arbiter #(.NUM_SRC(NUM_SRC), .PTR_W(PTR_W)) u_rr (
    .req   (req_s),
    .ptr   (rr_ptr_r),
    .grant (pick_s)
  );

  // One-hot to index conversion for the current grant and the new pick.
  always_comb begin
    g_idx_s    = {PTR_W{1'b0}};
    pick_idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      g_idx_s    = g_idx_s    | (grant_r[i] ? PTR_W'(i) : {PTR_W{1'b0}});
      pick_idx_s = pick_idx_s | (pick_s[i]  ? PTR_W'(i) : {PTR_W{1'b0}});
    end
  end

  // Granted-source stream mux; everything is forced to zero outside XFER.
  always_comb begin
    user_tvalid_s = 1'b0;
    user_tfirst_s = 1'b0;
    user_tlast_s  = 1'b0;
    user_tdata_s  = '0;
    user_tkeep_s  = '0;
    src_tready_s  = '0;
    if (state_r == XFER) begin
      user_tvalid_s         = src_tvalid_in[g_idx_s];
      user_tfirst_s         = src_tfirst_in[g_idx_s];
      user_tlast_s          = src_tlast_in[g_idx_s];
      user_tdata_s          = src_tdata_in[g_idx_s*DATA_W +: DATA_W];
      user_tkeep_s          = src_tkeep_in[g_idx_s*KEEP_W +: KEEP_W];
      src_tready_s[g_idx_s] = user_tready_in;
    end else begin
      src_tready_s = '0;
    end
  end

  // Packet end and new-grant conditions.
  always_comb begin
    hs_last_s = (state_r == XFER) && user_tvalid_s && user_tready_in && user_tlast_s;
    take_s    = (state_r == IDLE) && (|req_s) && !nwr_busy_in;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s) state_nxt_s = XFER;
        else        state_nxt_s = IDLE;
      end
      XFER: begin
        if (hs_last_s) state_nxt_s = nwr_done_in ? IDLE : WAIT_DONE;
        else           state_nxt_s = XFER;
      end
      WAIT_DONE: begin
        if (nwr_done_in || done_seen_r) state_nxt_s = IDLE;
        else                            state_nxt_s = WAIT_DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant, packet latches, rotation pointer and early-done capture.
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state_r     <= IDLE;
      arb_busy_r  <= 1'b0;
      grant_r     <= '0;
      tsize_r     <= '0;
      addr_r      <= '0;
      rr_ptr_r    <= PTR_W'(NUM_SRC - 1);
      done_seen_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      arb_busy_r <= (state_nxt_s != IDLE);
      if (take_s) begin
        grant_r <= pick_s;
        tsize_r <= src_tsize_in[pick_idx_s*SIZE_W +: SIZE_W];
        addr_r  <= src_addr_in[pick_idx_s*ADDR_W +: ADDR_W];
      end else if (state_nxt_s == IDLE) begin
        grant_r <= '0;
      end
      if (hs_last_s) begin
        rr_ptr_r <= g_idx_s;
      end
      // A done that beats the last beat is remembered for WAIT_DONE.
      if (state_nxt_s == IDLE) begin
        done_seen_r <= 1'b0;
      end else if ((state_r == XFER) && nwr_done_in) begin
        done_seen_r <= 1'b1;
      end
    end
  end

`ifdef NWR_ARB_STATS_EN
  logic [NUM_SRC*CNT_W-1:0] pkt_cnt_r;

  // Saturating per-source count of completed packets.
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      pkt_cnt_r <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (hs_last_s && grant_r[i] && (pkt_cnt_r[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          pkt_cnt_r[i*CNT_W +: CNT_W] <= pkt_cnt_r[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_r;
`endif

  assign src_tready_o  = src_tready_s;
  assign user_tvalid_o = user_tvalid_s;
  assign user_tfirst_o = user_tfirst_s;
  assign user_tlast_o  = user_tlast_s;
  assign user_tdata_o  = user_tdata_s;
  assign user_tkeep_o  = user_tkeep_s;
  assign user_tsize_o  = tsize_r;
  assign user_addr_o   = addr_r;
  assign grant_o       = grant_r;
  assign arb_busy_o    = arb_busy_r;

endmodule

// File: tb/tb_nwr_stream_arbiter.sv
// Scoreboard bench for nwr_stream_arbiter (two sources, default widths).
module tb_nwr_stream_arbiter;

  logic          log_clk, log_rst;
  logic [1:0]    src_tvalid_in, src_tready_o, src_tfirst_in, src_tlast_in;
  logic [127:0]  src_tdata_in;
  logic [15:0]   src_tkeep_in;
  logic [39:0]   src_tsize_in;
  logic [67:0]   src_addr_in;
  logic          user_tready_in, user_tvalid_o, user_tfirst_o, user_tlast_o;
  logic [63:0]   user_tdata_o;
  logic [7:0]    user_tkeep_o;
  logic [19:0]   user_tsize_o;
  logic [33:0]   user_addr_o;
  logic          nwr_busy_in, nwr_done_in;
  logic [1:0]    grant_o;
  logic          arb_busy_o;
`ifdef NWR_ARB_STATS_EN
  logic [31:0]   pkt_cnt_o;
`endif

  nwr_stream_arbiter #(.NUM_SRC(2)) dut (
    .log_clk(log_clk), .log_rst(log_rst),
    .src_tvalid_in(src_tvalid_in), .src_tready_o(src_tready_o),
    .src_tdata_in(src_tdata_in), .src_tkeep_in(src_tkeep_in),
    .src_tfirst_in(src_tfirst_in), .src_tlast_in(src_tlast_in),
    .src_tsize_in(src_tsize_in), .src_addr_in(src_addr_in),
    .user_tready_in(user_tready_in), .user_tvalid_o(user_tvalid_o),
    .user_tfirst_o(user_tfirst_o), .user_tlast_o(user_tlast_o),
    .user_tdata_o(user_tdata_o), .user_tkeep_o(user_tkeep_o),
    .user_tsize_o(user_tsize_o), .user_addr_o(user_addr_o),
    .nwr_busy_in(nwr_busy_in), .nwr_done_in(nwr_done_in),
    .grant_o(grant_o), .arb_busy_o(arb_busy_o)
`ifdef NWR_ARB_STATS_EN
    , .pkt_cnt_o(pkt_cnt_o)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        first;
    logic        last;
    logic [1:0]  grant;
    logic [33:0] addr;
    logic [19:0] size;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    done_delay = 3;
  logic  bp_en = 1'b0;
  logic  pend_idle = 1'b0;
  logic  prev_stall = 1'b0;
  logic [63:0] prev_data = 64'd0;

  initial log_clk = 1'b0;
  always #5 log_clk = ~log_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, req);
    end
  endtask

  task automatic push_pkt(input int s, input int nb, input logic [63:0] base,
                          input logic [33:0] addr, input logic [19:0] sz);
    beat_t e;
    for (int b = 0; b < nb; b++) begin
      e.data  = base + 64'(b);
      e.keep  = (b == nb - 1) ? 8'h0F : 8'hFF;
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      e.grant = (s == 0) ? 2'b01 : 2'b10;
      e.addr  = addr;
      e.size  = sz;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input int s, input int b, input int nb, input logic [63:0] base,
                            input logic [33:0] addr, input logic [19:0] sz);
    src_tvalid_in[s]          = 1'b1;
    src_tfirst_in[s]          = (b == 0);
    src_tlast_in[s]           = (b == nb - 1);
    src_tdata_in[s*64 +: 64]  = base + 64'(b);
    src_tkeep_in[s*8 +: 8]    = (b == nb - 1) ? 8'h0F : 8'hFF;
    src_tsize_in[s*20 +: 20]  = sz;
    src_addr_in[s*34 +: 34]   = addr;
  endtask

  task automatic wait_hs(input int s);
    logic hs;
    int   wd;
    hs = 1'b0;
    wd = 0;
    while (!hs && wd < 200) begin
      @(negedge log_clk);
      hs = src_tready_o[s];
      @(posedge log_clk);
      #1;
      wd++;
    end
    total++;
    if (!hs) begin
      bad++;
      $display("FAIL handshake_timeout src%0d: got=no_ready want=ready", s);
    end
  endtask

  task automatic send_pkt(input int s, input int nb, input logic [63:0] base,
                          input logic [33:0] addr, input logic [19:0] sz);
    for (int b = 0; b < nb; b++) begin
      drive_beat(s, b, nb, base, addr, sz);
      wait_hs(s);
    end
    src_tvalid_in[s] = 1'b0;
    src_tfirst_in[s] = 1'b0;
    src_tlast_in[s]  = 1'b0;
  endtask

  task automatic wait_idle();
    int wd;
    wd = 0;
    while (wd < 300 && !(exp_q.size() == 0 && !arb_busy_o && !nwr_done_in)) begin
      @(negedge log_clk);
      #1;
      wd++;
    end
    check("drain_idle", 64'({exp_q.size() != 0, arb_busy_o}), 64'd0);
  endtask

  task automatic clear_src();
    src_tvalid_in = '0; src_tfirst_in = '0; src_tlast_in = '0;
    src_tdata_in = '0; src_tkeep_in = '0; src_tsize_in = '0; src_addr_in = '0;
  endtask

  task automatic do_reset();
    @(posedge log_clk);
    #1;
    log_rst = 1'b1;
    repeat (2) @(posedge log_clk);
    #1;
    log_rst = 1'b0;
  endtask

  // NWRITE engine model: done pulse done_delay cycles after a tlast handshake.
  initial begin
    nwr_done_in = 1'b0;
    forever begin
      @(negedge log_clk);
      if (!log_rst && user_tvalid_o && user_tready_in && user_tlast_o) begin
        if (done_delay == 0) begin
          nwr_done_in = 1'b1;
          @(posedge log_clk);
          #1;
          nwr_done_in = 1'b0;
        end else begin
          repeat (done_delay) @(posedge log_clk);
          #1;
          nwr_done_in = 1'b1;
          @(posedge log_clk);
          #1;
          nwr_done_in = 1'b0;
        end
      end
    end
  end

  // Downstream backpressure generator.
  initial begin
    forever begin
      @(posedge log_clk);
      #1;
      if (bp_en) user_tready_in = ~user_tready_in;
    end
  end

  // Monitor: scoreboard pops, stall hold, grant exclusivity, release timing.
  initial begin
    forever begin
      @(negedge log_clk);
      #1;
      if (log_rst) begin
        pend_idle  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (pend_idle) check("busy_falls_after_done", 64'(arb_busy_o), 64'd0);
        pend_idle = nwr_done_in && arb_busy_o && (!user_tvalid_o || (user_tready_in && user_tlast_o));
        if (prev_stall && user_tvalid_o) check("stall_hold_data", user_tdata_o, prev_data);
        prev_stall = user_tvalid_o && !user_tready_in;
        prev_data  = user_tdata_o;
        if (arb_busy_o) check("other_tready_low", 64'(src_tready_o & ~grant_o), 64'd0);
        if (user_tvalid_o && user_tready_in) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got=%h want=none", user_tdata_o);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            if (user_tdata_o !== e.data || user_tkeep_o !== e.keep || user_tfirst_o !== e.first ||
                user_tlast_o !== e.last || grant_o !== e.grant || user_addr_o !== e.addr ||
                user_tsize_o !== e.size) begin
              bad++;
              $display("FAIL beat: got d=%h k=%h f=%b l=%b g=%b a=%h s=%0d want d=%h k=%h f=%b l=%b g=%b a=%h s=%0d",
                       user_tdata_o, user_tkeep_o, user_tfirst_o, user_tlast_o, grant_o, user_addr_o,
                       user_tsize_o, e.data, e.keep, e.first, e.last, e.grant, e.addr, e.size);
            end
          end
        end
      end
    end
  end

  initial begin
    log_rst = 1'b1;
    user_tready_in = 1'b1;
    nwr_busy_in = 1'b0;
    clear_src();
    repeat (2) @(posedge log_clk);
    #1;
    log_rst = 1'b0;

    // Reset state
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_busy", 64'(arb_busy_o), 64'd0);
    check("rst_size_addr", 64'({user_tsize_o, user_addr_o}), 64'd0);
    check("rst_stream", 64'({user_tvalid_o, user_tfirst_o, user_tlast_o, user_tkeep_o, src_tready_o}), 64'd0);

    // Single source packet
    done_delay = 3;
    push_pkt(0, 4, 64'hA0, 34'h1000, 20'd32);
    send_pkt(0, 4, 64'hA0, 34'h1000, 20'd32);
    wait_idle();
    check("hold_addr", 64'(user_addr_o), 64'h1000);
    check("hold_size", 64'(user_tsize_o), 64'd32);
    check("idle_grant", 64'(grant_o), 64'd0);

    // Contention: alternating grants starting at source 0
    do_reset();
    done_delay = 1;
    push_pkt(0, 2, 64'h100, 34'h2000, 20'd16);
    push_pkt(1, 2, 64'h200, 34'h3000, 20'd16);
    push_pkt(0, 2, 64'h300, 34'h4000, 20'd16);
    push_pkt(1, 2, 64'h400, 34'h5000, 20'd16);
    fork
      begin
        send_pkt(0, 2, 64'h100, 34'h2000, 20'd16);
        send_pkt(0, 2, 64'h300, 34'h4000, 20'd16);
      end
      begin
        send_pkt(1, 2, 64'h200, 34'h3000, 20'd16);
        send_pkt(1, 2, 64'h400, 34'h5000, 20'd16);
      end
    join
    wait_idle();

    // Backpressure mid-packet
    done_delay = 2;
    bp_en = 1'b1;
    push_pkt(1, 4, 64'hB00, 34'h6000, 20'd32);
    send_pkt(1, 4, 64'hB00, 34'h6000, 20'd32);
    bp_en = 1'b0;
    @(posedge log_clk);
    #2;
    user_tready_in = 1'b1;
    wait_idle();

    // Busy gating
    done_delay = 1;
    nwr_busy_in = 1'b1;
    push_pkt(1, 2, 64'hC00, 34'h7000, 20'd16);
    fork
      send_pkt(1, 2, 64'hC00, 34'h7000, 20'd16);
    join_none
    for (int c = 0; c < 4; c++) begin
      @(negedge log_clk);
      #1;
      check("busy_blocks_grant", 64'(grant_o), 64'd0);
    end
    @(posedge log_clk);
    #1;
    nwr_busy_in = 1'b0;
    @(negedge log_clk);
    #1;
    check("grant_not_before_edge", 64'(grant_o), 64'd0);
    @(negedge log_clk);
    #1;
    check("grant_after_busy", 64'(grant_o), 64'b10);
    wait fork;
    wait_idle();

    // Done in the same cycle as the tlast handshake
    done_delay = 0;
    push_pkt(0, 2, 64'hD00, 34'h8000, 20'd16);
    send_pkt(0, 2, 64'hD00, 34'h8000, 20'd16);
    check("same_cycle_done_idle", 64'(arb_busy_o), 64'd0);
    wait_idle();

`ifdef NWR_ARB_STATS_EN
    check("cnt_before_reset", 64'(pkt_cnt_o), 64'({16'd4, 16'd3}));
`endif

    // Reset in the middle of a packet
    done_delay = 1;
    push_pkt(1, 1, 64'hE00, 34'h9000, 20'd32);
    exp_q[0].last = 1'b0;
    exp_q[0].keep = 8'hFF;
    drive_beat(1, 0, 4, 64'hE00, 34'h9000, 20'd32);
    wait_hs(1);
    drive_beat(1, 1, 4, 64'hE00, 34'h9000, 20'd32);
    #2;
    log_rst = 1'b1;
    #1;
    check("mid_rst_grant", 64'(grant_o), 64'd0);
    check("mid_rst_busy", 64'(arb_busy_o), 64'd0);
    check("mid_rst_stream", 64'({user_tvalid_o, user_tfirst_o, user_tlast_o, user_tkeep_o, src_tready_o}), 64'd0);
    check("mid_rst_data", user_tdata_o, 64'd0);
    check("mid_rst_size_addr", 64'({user_tsize_o, user_addr_o}), 64'd0);
    clear_src();
    repeat (2) @(posedge log_clk);
    #1;
    log_rst = 1'b0;
    check("scoreboard_empty_after_rst", 64'(exp_q.size()), 64'd0);
`ifdef NWR_ARB_STATS_EN
    check("cnt_after_reset", 64'(pkt_cnt_o), 64'd0);
`endif
    for (int p = 0; p < 3; p++) begin
      push_pkt(1, 2, 64'hF00 + 64'(p * 16), 34'hA000, 20'd16);
      send_pkt(1, 2, 64'hF00 + 64'(p * 16), 34'hA000, 20'd16);
      wait_idle();
    end
`ifdef NWR_ARB_STATS_EN
    check("cnt_src1", 64'(pkt_cnt_o[31:16]), 64'd3);
    check("cnt_src0", 64'(pkt_cnt_o[15:0]), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
